// File: rtl/gcd_control_if.sv
// gcd_control_if
//   Signal bundle between the subtractive-GCD control FSM and its
//   environment (requester + datapath).
//   Requester side : go, xin, yin in; ready, done, err, iter_cnt out.
//   Datapath side  : eqflg, ltflg in; xmsel, ymsel, xld, yld, gld out.
//   modport slave  : the controller (gcd_control).
//   modport master : whatever drives go/operands and returns the flags.
interface gcd_control_if #(
    parameter int unsigned W        = 4,
    parameter int unsigned MAX_ITER = 15
);
    localparam int unsigned CW = $clog2(MAX_ITER + 1);

    logic          go;
    logic [W-1:0]  xin;
    logic [W-1:0]  yin;
    logic          eqflg;
    logic          ltflg;
    logic          xmsel;
    logic          ymsel;
    logic          xld;
    logic          yld;
    logic          gld;
    logic          ready;
    logic          done;
    logic          err;
    logic [CW-1:0] iter_cnt;

    modport slave (
        input  go, xin, yin, eqflg, ltflg,
        output xmsel, ymsel, xld, yld, gld, ready, done, err, iter_cnt
    );

    modport master (
        output go, xin, yin, eqflg, ltflg,
        input  xmsel, ymsel, xld, yld, gld, ready, done, err, iter_cnt
    );
endinterface

// File: rtl/gcd_control.sv
// gcd_control
//   Control FSM for a subtractive GCD datapath. On go (sampled in IDLE)
//   it loads xin/yin into the datapath x/y registers, then alternates a
//   compare cycle with one subtract cycle (x<=x-y or y<=y-x) until the
//   datapath reports x==y, at which point it loads the gcd register and
//   pulses done. Zero operands or an exhausted iteration budget pulse err
//   instead and leave the gcd register untouched.
//
//   Ports
//     clk : rising-edge clock
//     clr : synchronous active-high reset (forces IDLE, iter_cnt=0)
//     bus : gcd_control_if.slave
//           in  go, xin, yin, eqflg, ltflg
//           out xmsel, ymsel, xld, yld, gld, ready, done, err, iter_cnt
//
//   All outputs are registered and decoded from the state only; there is
//   no combinational path from any input to any output.
module gcd_control #(
    parameter int unsigned W        = 4,
    parameter int unsigned MAX_ITER = 15
) (
    input  logic           clk,
    input  logic           clr,
    gcd_control_if.slave   bus
);
    localparam int unsigned CW = $clog2(MAX_ITER + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CMP,
        SUBX,
        SUBY,
        GLD,
        DONE,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] iter_q,  iter_d;

    logic xmsel_q, xmsel_d;
    logic ymsel_q, ymsel_d;
    logic xld_q,   xld_d;
    logic yld_q,   yld_d;
    logic gld_q,   gld_d;
    logic ready_q, ready_d;
    logic done_q,  done_d;
    logic err_q,   err_d;

    // Next-state and iteration counter.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        unique case (state_q)
            IDLE: begin
                if (bus.go) begin
                    state_d = LOAD;
                    iter_d  = '0;
                end
            end
            LOAD: begin
                if (bus.xin == '0 || bus.yin == '0) begin
                    state_d = ERR;
                end else begin
                    state_d = CMP;
                end
            end
            CMP: begin
                // Equality wins over the budget check, so a result that
                // converges on the last permitted subtraction still completes.
                if (bus.eqflg) begin
                    state_d = GLD;
                end else if (iter_q == CW'(MAX_ITER)) begin
                    state_d = ERR;
                end else if (bus.ltflg) begin
                    state_d = SUBY;
                end else begin
                    state_d = SUBX;
                end
            end
            SUBX, SUBY: begin
                // Only reachable while iter_q < MAX_ITER, so this never wraps.
                state_d = CMP;
                iter_d  = iter_q + CW'(1);
            end
            GLD:     state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state, registered alongside the state so
    // the strobes are active in the same cycle as the state they belong to.
    always_comb begin
        xmsel_d = 1'b0;
        ymsel_d = 1'b0;
        xld_d   = 1'b0;
        yld_d   = 1'b0;
        gld_d   = 1'b0;
        ready_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_d)
            IDLE: ready_d = 1'b1;
            LOAD: begin
                xmsel_d = 1'b1;
                ymsel_d = 1'b1;
                xld_d   = 1'b1;
                yld_d   = 1'b1;
            end
            CMP:  ;
            SUBX: xld_d  = 1'b1;
            SUBY: yld_d  = 1'b1;
            GLD:  gld_d  = 1'b1;
            DONE: done_d = 1'b1;
            ERR:  err_d  = 1'b1;
            default: ready_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            iter_q  <= '0;
            xmsel_q <= 1'b0;
            ymsel_q <= 1'b0;
            xld_q   <= 1'b0;
            yld_q   <= 1'b0;
            gld_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            xmsel_q <= xmsel_d;
            ymsel_q <= ymsel_d;
            xld_q   <= xld_d;
            yld_q   <= yld_d;
            gld_q   <= gld_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.xmsel    = xmsel_q;
    assign bus.ymsel    = ymsel_q;
    assign bus.xld      = xld_q;
    assign bus.yld      = yld_q;
    assign bus.gld      = gld_q;
    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.iter_cnt = iter_q;
endmodule

// File: tb/tb_gcd_control.sv
// tb_gcd_control
//   Directed bench for gcd_control. Two controllers are instantiated, one
//   with the default budget (MAX_ITER=15) and one with MAX_ITER=3, each
//   driving a small behavioural x/y/gcd datapath that supplies eqflg/ltflg.
//   Edge 0 is the clock edge just before go is raised.
module tb_gcd_control;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    gcd_control_if #(.W(W), .MAX_ITER(15)) bus_a ();
    gcd_control_if #(.W(W), .MAX_ITER(3))  bus_b ();

    gcd_control #(.W(W), .MAX_ITER(15)) dut_a (.clk(clk), .clr(clr), .bus(bus_a));
    gcd_control #(.W(W), .MAX_ITER(3))  dut_b (.clk(clk), .clr(clr), .bus(bus_b));

    // Behavioural datapaths steered by the controllers.
    logic [W-1:0] xa, ya, ga, xb, yb, gb;
    always @(posedge clk) begin
        if (bus_a.xld) xa <= bus_a.xmsel ? bus_a.xin : xa - ya;
        if (bus_a.yld) ya <= bus_a.ymsel ? bus_a.yin : ya - xa;
        if (bus_a.gld) ga <= xa;
        if (bus_b.xld) xb <= bus_b.xmsel ? bus_b.xin : xb - yb;
        if (bus_b.yld) yb <= bus_b.ymsel ? bus_b.yin : yb - xb;
        if (bus_b.gld) gb <= xb;
    end
    assign bus_a.eqflg = (xa == ya);
    assign bus_a.ltflg = (xa <  ya);
    assign bus_b.eqflg = (xb == yb);
    assign bus_b.ltflg = (xb <  yb);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output vector: {ready, xmsel, ymsel, xld, yld, gld, done, err}
    localparam logic [7:0] ST_IDLE = 8'b1000_0000;
    localparam logic [7:0] ST_LOAD = 8'b0111_1000;

    task automatic sample(input bit b, output logic [7:0] st, output int it);
        if (b) begin
            st = {bus_b.ready, bus_b.xmsel, bus_b.ymsel, bus_b.xld,
                  bus_b.yld, bus_b.gld, bus_b.done, bus_b.err};
            it = int'(bus_b.iter_cnt);
        end else begin
            st = {bus_a.ready, bus_a.xmsel, bus_a.ymsel, bus_a.xld,
                  bus_a.yld, bus_a.gld, bus_a.done, bus_a.err};
            it = int'(bus_a.iter_cnt);
        end
    endtask

    task automatic set_go(input bit b, input logic v);
        if (b) bus_b.go = v;
        else   bus_a.go = v;
    endtask

    // Results of the most recent run_op.
    int done_e, err_e, rdy_e, subx_n, suby_n, gld_n, excl_bad, last_it;

    // Called #1 after an edge (edge 0). Raises go with the operands and
    // watches until ready returns; mid_go re-asserts go for one cycle after
    // that edge number, hold_go keeps go high throughout.
    task automatic run_op(input bit b, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int mid_go, input bit hold_go);
        logic [7:0] st;
        int it;
        int e;
        done_e = -1; err_e = -1; rdy_e = -1;
        subx_n = 0; suby_n = 0; gld_n = 0; excl_bad = 0;
        if (b) begin bus_b.xin = x; bus_b.yin = y; end
        else   begin bus_a.xin = x; bus_a.yin = y; end
        set_go(b, 1'b1);
        e = 0;
        while (rdy_e < 0 && e < 100) begin
            @(posedge clk); #1;
            e++;
            set_go(b, hold_go || (e == mid_go));
            sample(b, st, it);
            if (st[1]) done_e = e;
            if (st[0]) err_e  = e;
            if (st[2]) gld_n++;
            if (st[4] && !st[6]) subx_n++;
            if (st[3] && !st[5]) suby_n++;
            if (!(st[6] && st[5]) && (int'(st[4]) + int'(st[3]) + int'(st[2]) > 1))
                excl_bad++;
            if (st[7]) rdy_e = e;
        end
        last_it = it;
        check("op_timeout", (rdy_e >= 0) ? 1 : 0, 1);
    endtask

    initial begin
        logic [7:0] st;
        int it;
        int ev;

        clr = 1'b1;
        bus_a.go = 1'b0; bus_a.xin = '0; bus_a.yin = '0;
        bus_b.go = 1'b0; bus_b.xin = '0; bus_b.yin = '0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;

        // Reset/idle state held with go low.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            sample(1'b0, st, it);
            check("rst_outputs", int'(st), int'(ST_IDLE));
            check("rst_iter", it, 0);
        end

        // Give the MAX_ITER=3 datapath a known gcd value.
        run_op(1'b1, 4'd7, 4'd7, -1, 1'b0);
        check("b77_done_edge", done_e, 4);
        check("b77_gcd", int'(gb), 7);

        // gcd(12,8): SUBX then SUBY.
        run_op(1'b0, 4'd12, 4'd8, -1, 1'b0);
        check("a128_done_edge", done_e, 8);
        check("a128_err_edge", err_e, -1);
        check("a128_gcd", int'(ga), 4);
        check("a128_iter", last_it, 2);
        check("a128_subx", subx_n, 1);
        check("a128_suby", suby_n, 1);
        check("a128_excl", excl_bad, 0);

        // Equal operands: no subtraction.
        run_op(1'b0, 4'd7, 4'd7, -1, 1'b0);
        check("a77_done_edge", done_e, 4);
        check("a77_gcd", int'(ga), 7);
        check("a77_iter", last_it, 0);
        check("a77_subs", subx_n + suby_n, 0);

        // Worst case for W=4 with default budget.
        run_op(1'b0, 4'd15, 4'd1, -1, 1'b0);
        check("a151_done_edge", done_e, 32);
        check("a151_gcd", int'(ga), 1);
        check("a151_iter", last_it, 14);
        check("a151_subx", subx_n, 14);
        check("a151_excl", excl_bad, 0);

        // Same operands against a budget of 3: abort.
        run_op(1'b1, 4'd15, 4'd1, -1, 1'b0);
        check("b151_err_edge", err_e, 9);
        check("b151_done_edge", done_e, -1);
        check("b151_gld", gld_n, 0);
        check("b151_iter", last_it, 3);
        check("b151_gcd_kept", int'(gb), 7);

        // Zero operand.
        run_op(1'b0, 4'd0, 4'd5, -1, 1'b0);
        check("a05_err_edge", err_e, 2);
        check("a05_ready_edge", rdy_e, 3);
        check("a05_subs", subx_n + suby_n, 0);
        check("a05_gld", gld_n, 0);
        check("a05_gcd_kept", int'(ga), 1);

        // gcd(9,6) with a stray go pulse mid-operation.
        run_op(1'b0, 4'd9, 4'd6, 4, 1'b0);
        check("a96go_done_edge", done_e, 8);
        check("a96go_gcd", int'(ga), 3);
        check("a96go_iter", last_it, 2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            sample(1'b0, st, it);
            check("a96go_stays_idle", int'(st), int'(ST_IDLE));
        end

        // gcd(9,6) aborted by clr while in SUBX.
        bus_a.xin = 4'd9; bus_a.yin = 4'd6; bus_a.go = 1'b1;
        @(posedge clk); #1 bus_a.go = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sample(1'b0, st, it);
        check("clr_in_subx", int'(st[4] && !st[6]), 1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        sample(1'b0, st, it);
        check("clr_outputs", int'(st), int'(ST_IDLE));
        check("clr_iter", it, 0);
        ev = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            sample(1'b0, st, it);
            if (st != ST_IDLE) ev++;
        end
        check("clr_no_activity", ev, 0);

        // go held high: restart on the cycle after returning to IDLE.
        run_op(1'b0, 4'd7, 4'd7, -1, 1'b1);
        check("hold_done_edge", done_e, 4);
        check("hold_ready_edge", rdy_e, 5);
        @(posedge clk); #1;
        bus_a.go = 1'b0;
        sample(1'b0, st, it);
        check("hold_restart_load", int'(st), int'(ST_LOAD));
        repeat (4) @(posedge clk);
        #1;
        sample(1'b0, st, it);
        check("hold_second_ready", int'(st), int'(ST_IDLE));
        check("hold_second_gcd", int'(ga), 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
